// File: rtl/key_led_ctrl.sv
// key_led_ctrl: single-key LED mode controller.
// The raw key is synchronised, debounced and edge-detected; each accepted
// press steps the mode OFF -> ON -> SLOW -> FAST -> OFF, and the LED is driven
// from the mode and a free-running blink timer.
module key_led_ctrl #(
  parameter int CNT_DEBOUNCE = 1_000_000,
  parameter int SLOW_HALF    = 25_000_000,
  parameter int FAST_HALF    = 5_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key,
  output logic       led,
  output logic [1:0] mode,
  output logic       key_flag
);

  localparam int DW = $clog2(CNT_DEBOUNCE);
  localparam int BW = $clog2(SLOW_HALF);

  localparam logic [DW-1:0] DB_LAST   = DW'(CNT_DEBOUNCE - 1);
  localparam logic [BW-1:0] SLOW_LAST = BW'(SLOW_HALF - 1);
  localparam logic [BW-1:0] FAST_LAST = BW'(FAST_HALF - 1);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_ON   = 2'd1,
    MODE_SLOW = 2'd2,
    MODE_FAST = 2'd3
  } mode_t;

  logic          key_p0;
  logic          key_p1;
  logic          key_stable;
  logic [DW-1:0] db_cnt;
  mode_t         state;
  logic [BW-1:0] blink_cnt;
  logic          phase;

  // Terminal count of the blink timer for the current blink mode.
  function automatic logic [BW-1:0] half_last(input mode_t m);
    return (m == MODE_FAST) ? FAST_LAST : SLOW_LAST;
  endfunction

  assign mode = state;

  // Two-flop synchroniser for the asynchronous key pin; idles released.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
    end else begin
      key_p0 <= key;
      key_p1 <= key_p0;
    end
  end

  // Debounce: accept a new level after it holds for CNT_DEBOUNCE cycles and
  // pulse key_flag only on the accepted released->pressed transition.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      key_stable <= 1'b1;
      db_cnt     <= '0;
      key_flag   <= 1'b0;
    end else begin
      key_flag <= 1'b0;
      if (key_p1 == key_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_stable <= key_p1;
        db_cnt     <= '0;
        key_flag   <= key_stable;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Mode FSM: every press advances one mode, wrapping FAST back to OFF.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= MODE_OFF;
    end else if (key_flag) begin
      state <= mode_t'(state + 2'd1);
    end
  end

  // Blink timer: restarts lit on every mode change, which overrides a wrap
  // landing on the same edge; idles at count 0, phase 1 outside blink modes.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (key_flag) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (state == MODE_SLOW || state == MODE_FAST) begin
      if (blink_cnt == half_last(state)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end
  end

  // Registered LED drive from the current mode and blink phase.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      led <= 1'b0;
    end else begin
      unique case (state)
        MODE_OFF: led <= 1'b0;
        MODE_ON:  led <= 1'b1;
        default:  led <= phase;
      endcase
    end
  end

endmodule

// File: tb/tb_key_led_ctrl.sv
// Testbench for key_led_ctrl with short debounce and blink periods.
module tb_key_led_ctrl;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key       = 1'b1;
  logic       led;
  logic [1:0] mode;
  logic       key_flag;

  int n_checks = 0;
  int n_fail   = 0;

  key_led_ctrl #(
    .CNT_DEBOUNCE(4),
    .SLOW_HALF   (8),
    .FAST_HALF   (2)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key      (key),
    .led      (led),
    .mode     (mode),
    .key_flag (key_flag)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       rst_n;
    logic       k;
    logic       exp_led;
    logic [1:0] exp_mode;
    logic       exp_flag;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic k, input int n,
                     input logic l, input logic [1:0] m, input logic f);
    vec_t v;
    v.rst_n = r; v.k = k; v.exp_led = l; v.exp_mode = m; v.exp_flag = f;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive key for n cycles and return how many key_flag pulses were seen.
  task automatic hold(input logic k, input int n, output int flags);
    flags = 0;
    key = k;
    for (int i = 0; i < n; i++) begin
      step();
      if (key_flag === 1'b1) flags++;
    end
  endtask

  int   f_press, f_rel, total, flag_at;
  logic bounce [14];

  initial begin
    // Reset, idle, rejected glitch, first accepted press and its release.
    add(1'b0, 1'b1, 3,  1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 50, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b0, 3,  1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 10, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b0, 5,  1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b0, 1,  1'b0, 2'd0, 1'b1);
    add(1'b1, 1'b0, 1,  1'b0, 2'd1, 1'b0);
    add(1'b1, 1'b0, 13, 1'b1, 2'd1, 1'b0);
    add(1'b1, 1'b1, 10, 1'b1, 2'd1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      sys_rst_n = vecs[i].rst_n;
      key       = vecs[i].k;
      step();
      check($sformatf("vec%0d_led", i),  led,      vecs[i].exp_led);
      check($sformatf("vec%0d_mode", i), mode,     vecs[i].exp_mode);
      check($sformatf("vec%0d_flag", i), key_flag, vecs[i].exp_flag);
    end

    // Four clean presses from ON: 2, 3, 0, 1; one flag per press, none on release.
    total = 0;
    for (int p = 0; p < 4; p++) begin
      hold(1'b0, 10, f_press);
      hold(1'b1, 10, f_rel);
      total += f_press + f_rel;
      check($sformatf("press%0d_flags", p), f_press, 1);
      check($sformatf("release%0d_flags", p), f_rel, 0);
      check($sformatf("press%0d_mode", p), mode, (p + 2) % 4);
    end
    check("four_press_total_flags", total, 4);

    // Press into SLOW: flag on edge 6, mode on edge 7, then 8 lit / 8 dark.
    key = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 6) check("slow_press_flag", key_flag, 1);
    end
    step();
    check("slow_mode", mode, 2);
    total = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (key_flag === 1'b1) total++;
      check($sformatf("slow_led_k%0d", k), led, (((k - 1) / 8) % 2 == 0) ? 1 : 0);
    end
    check("held_key_extra_flags", total, 0);
    check("slow_mode_held", mode, 2);

    // Release, then press into FAST: restarts lit, toggles every 2 cycles.
    hold(1'b1, 10, f_rel);
    check("slow_release_flags", f_rel, 0);
    key = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 6) check("fast_press_flag", key_flag, 1);
    end
    step();
    check("fast_mode", mode, 3);
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("fast_led_k%0d", k), led, (((k - 1) / 2) % 2 == 0) ? 1 : 0);
    end

    // Reset for one cycle in FAST, midway through debouncing a new press.
    hold(1'b1, 10, f_rel);
    key = 1'b0;
    repeat (3) step();
    sys_rst_n = 1'b0;
    step();
    check("rst_mid_mode", mode, 0);
    check("rst_mid_led", led, 0);
    check("rst_mid_flag", key_flag, 0);
    sys_rst_n = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      step();
      check($sformatf("post_rst_flag_r%0d", r), key_flag, (r == 6) ? 1 : 0);
      check($sformatf("post_rst_mode_r%0d", r), mode, (r >= 7) ? 1 : 0);
      check($sformatf("post_rst_led_r%0d", r), led, (r >= 8) ? 1 : 0);
    end

    // Bounce 0,1,0,1 then held low: a single flag, 4 edges after key_sync settles.
    hold(1'b1, 10, f_rel);
    bounce[0] = 1'b0; bounce[1] = 1'b1; bounce[2] = 1'b0; bounce[3] = 1'b1;
    for (int b = 4; b < 14; b++) bounce[b] = 1'b0;
    total   = 0;
    flag_at = -1;
    for (int b = 0; b < 14; b++) begin
      key = bounce[b];
      step();
      if (key_flag === 1'b1) begin
        total++;
        flag_at = b + 1;
      end
    end
    check("bounce_flag_count", total, 1);
    check("bounce_flag_edge", flag_at, 10);
    check("bounce_mode", mode, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
